// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg
// Shared types and constants for the pipeline hazard controller:
//   - dbg_state_e    : debug FSM states (RUN, DRAIN, HALTED, STEP)
//   - CAUSE_*        : stall_cause encodings
//   - DRAIN_CYCLES_DEF: default number of cycles needed to empty the back end
//   - reads_reg()    : does the IF/ID instruction really read register rd
package pipeline_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2,
      ST_STEP   = 2'd3
   } dbg_state_e;

   localparam logic [2:0] CAUSE_NONE     = 3'd0;
   localparam logic [2:0] CAUSE_LOAD_USE = 3'd1;
   localparam logic [2:0] CAUSE_BRANCH   = 3'd2;
   localparam logic [2:0] CAUSE_FREEZE   = 3'd3;
   localparam logic [2:0] CAUSE_DEBUG    = 3'd4;

   localparam int DRAIN_CYCLES_DEF = 3;

   // x0 is hardwired to zero, so a producer writing it never conflicts.
   function automatic logic reads_reg(input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic use1,
                                      input logic [4:0] rs2, input logic use2);
      return (rd != 5'd0) && ((use1 && (rs1 == rd)) || (use2 && (rs2 == rd)));
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// hazard_detect
// Purely combinational detection of hazards the forwarding network cannot
// cover.
//   in : id_rs1/id_rs2 + id_use_rs1/id_use_rs2 (sources of IF/ID), id_branch,
//        ex_regw/ex_memr/ex_rd (ID/EX producer), mem_memr/mem_rd (EX/MEM)
//   out: load_use  - a load in EX feeds the instruction in ID
//        br_hazard - a branch in ID needs a value that is not yet available
//                    (ALU result in EX, or load data still in MEM)
module hazard_detect
   import pipeline_hazard_ctrl_pkg::*;
(
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_use_rs1,
   input  logic       id_use_rs2,
   input  logic       id_branch,
   input  logic       ex_regw,
   input  logic       ex_memr,
   input  logic [4:0] ex_rd,
   input  logic       mem_memr,
   input  logic [4:0] mem_rd,
   output logic       load_use,
   output logic       br_hazard
);

   logic ex_match;
   logic mem_match;

   assign ex_match  = reads_reg(ex_rd,  id_rs1, id_use_rs1, id_rs2, id_use_rs2);
   assign mem_match = reads_reg(mem_rd, id_rs1, id_use_rs1, id_rs2, id_use_rs2);

   assign load_use  = ex_memr & ex_match;
   // Branches compare in ID, so even an ALU result in EX is too late.
   assign br_hazard = id_branch & ((ex_regw & ex_match) | (mem_memr & mem_match));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Stall/flush/freeze sequencer for the 5-stage pipeline with a debug
// halt / single-step FSM.
//   in : clk, reset (async, active high), ID source/branch info, ID/EX and
//        EX/MEM producer info, dmem_busy, dbg_halt (level), dbg_step (pulse)
//   out: pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush,
//        id_ex_bubble, halted, stall_cause, stall_cnt, flush_cnt
// Optional feature macro: HAZARD_PERF_CNT_EN builds the stall/flush perf
// counters; without it both counter ports read as zero.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             id_branch,
   input  logic             id_branch_taken,
   input  logic             ex_regw,
   input  logic             ex_memr,
   input  logic [4:0]       ex_rd,
   input  logic             mem_memr,
   input  logic [4:0]       mem_rd,
   input  logic             dmem_busy,
   input  logic             dbg_halt,
   input  logic             dbg_step,
   output logic             pc_we,
   output logic             if_id_we,
   output logic             id_ex_we,
   output logic             ex_mem_we,
   output logic             mem_wb_we,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             halted,
   output logic [2:0]       stall_cause,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [1:0] DRAIN_LD = DRAIN_CYCLES[1:0];

   dbg_state_e state_q, state_d;
   logic [1:0] drain_cnt_q, drain_cnt_d;
   logic       load_use, br_hazard;

   hazard_detect u_hazard_detect (
      .id_rs1     (id_rs1),
      .id_rs2     (id_rs2),
      .id_use_rs1 (id_use_rs1),
      .id_use_rs2 (id_use_rs2),
      .id_branch  (id_branch),
      .ex_regw    (ex_regw),
      .ex_memr    (ex_memr),
      .ex_rd      (ex_rd),
      .mem_memr   (mem_memr),
      .mem_rd     (mem_rd),
      .load_use   (load_use),
      .br_hazard  (br_hazard)
   );

   // Stage control: freeze > halted > hazard > (flush, drain) > normal.
   always_comb begin
      pc_we        = 1'b1;
      if_id_we     = 1'b1;
      id_ex_we     = 1'b1;
      ex_mem_we    = 1'b1;
      mem_wb_we    = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      stall_cause  = CAUSE_NONE;
      if (dmem_busy || state_q == ST_HALTED) begin
         pc_we       = 1'b0;
         if_id_we    = 1'b0;
         id_ex_we    = 1'b0;
         ex_mem_we   = 1'b0;
         mem_wb_we   = 1'b0;
         stall_cause = dmem_busy ? CAUSE_FREEZE : CAUSE_DEBUG;
      end else if (load_use || br_hazard) begin
         pc_we        = 1'b0;
         if_id_we     = 1'b0;
         id_ex_bubble = 1'b1;
         stall_cause  = load_use ? CAUSE_LOAD_USE : CAUSE_BRANCH;
      end else begin
         if_id_flush = id_branch_taken;
         // Stop issue while the back end empties; later stages keep moving.
         if (state_q == ST_DRAIN) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_bubble = 1'b1;
            stall_cause  = CAUSE_DEBUG;
         end
      end
   end

   // Debug FSM next state.
   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      unique case (state_q)
         ST_RUN: if (dbg_halt) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DRAIN_LD;
         end
         ST_DRAIN: if (!dmem_busy) begin
            // The edge that takes the counter to zero also enters HALTED.
            if (drain_cnt_q <= 2'd1) begin
               state_d     = ST_HALTED;
               drain_cnt_d = 2'd0;
            end else begin
               drain_cnt_d = drain_cnt_q - 2'd1;
            end
         end
         ST_HALTED: begin
            if (!dbg_halt)     state_d = ST_RUN;
            else if (dbg_step) state_d = ST_STEP;
         end
         ST_STEP: if (pc_we) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DRAIN_LD;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_RUN;
         drain_cnt_q <= 2'd0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
      end
   end

   assign halted = (state_q == ST_HALTED);

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             stall_inc;

   // Only program-visible stalls count; debug drain/halt time is excluded.
   assign stall_inc = !pc_we && (state_q == ST_RUN || state_q == ST_STEP);

   always_comb begin
      stall_cnt_d = stall_cnt_q + CNT_W'(stall_inc);
      flush_cnt_d = flush_cnt_q + CNT_W'(if_id_flush);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: a driver issues directed and
// random stimulus, predicts the response from a behavioural model and queues
// it; a monitor pops and compares on every falling edge.
module tb_pipeline_hazard_ctrl;
   localparam int DRAIN = 3;
   localparam int CNT_W = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic [4:0]       id_rs1, id_rs2, ex_rd, mem_rd;
   logic             id_use_rs1, id_use_rs2, id_branch, id_branch_taken;
   logic             ex_regw, ex_memr, mem_memr, dmem_busy, dbg_halt, dbg_step;
   logic             pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
   logic             if_id_flush, id_ex_bubble, halted;
   logic [2:0]       stall_cause;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_branch(id_branch), .id_branch_taken(id_branch_taken),
      .ex_regw(ex_regw), .ex_memr(ex_memr), .ex_rd(ex_rd),
      .mem_memr(mem_memr), .mem_rd(mem_rd), .dmem_busy(dmem_busy),
      .dbg_halt(dbg_halt), .dbg_step(dbg_step),
      .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we),
      .mem_wb_we(mem_wb_we), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
      .halted(halted), .stall_cause(stall_cause), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] rs1, rs2;
      logic       use1, use2, br, tk, ex_regw, ex_memr;
      logic [4:0] ex_rd;
      logic       mem_memr;
      logic [4:0] mem_rd;
      logic       busy, halt, step;
   } stim_t;

   typedef struct {
      logic [4:0]       en;   // {pc, if_id, id_ex, ex_mem, mem_wb}
      logic             flush, bubble;
      logic [2:0]       cause;
      logic             halted;
      logic [CNT_W-1:0] scnt, fcnt;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0, n_bad = 0, n_pcwe = 0;

   // Behavioural model: halted flag, remaining drain cycles, pending step.
   bit               m_halted, m_stepping;
   int               m_drain;
   logic [CNT_W-1:0] m_scnt, m_fcnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit reads(input stim_t s, input logic [4:0] r);
      return (r != 0) && ((s.use1 && s.rs1 == r) || (s.use2 && s.rs2 == r));
   endfunction

   function automatic exp_t predict(input stim_t s);
      exp_t e;
      bit lu, br;
      lu = s.ex_memr && reads(s, s.ex_rd);
      br = s.br && ((s.ex_regw && reads(s, s.ex_rd)) || (s.mem_memr && reads(s, s.mem_rd)));
      e.en = 5'b11111; e.flush = 0; e.bubble = 0; e.cause = 0;
      e.halted = m_halted; e.scnt = m_scnt; e.fcnt = m_fcnt;
      if (s.busy) begin
         e.en = 5'b00000; e.cause = 3;
      end else if (m_halted) begin
         e.en = 5'b00000; e.cause = 4;
      end else if (lu || br) begin
         e.en = 5'b00111; e.bubble = 1; e.cause = lu ? 3'd1 : 3'd2;
      end else begin
         e.flush = s.tk;
         if (m_drain > 0) begin
            e.en = 5'b00111; e.bubble = 1; e.cause = 4;
         end
      end
      return e;
   endfunction

   task automatic model_reset();
      m_halted = 0; m_stepping = 0; m_drain = 0; m_scnt = '0; m_fcnt = '0;
   endtask

   task automatic advance(input stim_t s, input exp_t e);
`ifdef HAZARD_PERF_CNT_EN
      if (!e.en[4] && !m_halted && m_drain == 0) m_scnt = m_scnt + 1'b1;
      if (e.flush) m_fcnt = m_fcnt + 1'b1;
`endif
      if (m_halted) begin
         if (!s.halt) m_halted = 0;
         else if (s.step) begin m_halted = 0; m_stepping = 1; end
      end else if (m_drain > 0) begin
         if (!s.busy) begin
            m_drain--;
            if (m_drain == 0) m_halted = 1;
         end
      end else if (m_stepping) begin
         if (e.en[4]) begin m_stepping = 0; m_drain = DRAIN; end
      end else if (s.halt) begin
         m_drain = DRAIN;
      end
   endtask

   task automatic apply(input stim_t s);
      id_rs1 = s.rs1; id_rs2 = s.rs2; id_use_rs1 = s.use1; id_use_rs2 = s.use2;
      id_branch = s.br; id_branch_taken = s.tk; ex_regw = s.ex_regw; ex_memr = s.ex_memr;
      ex_rd = s.ex_rd; mem_memr = s.mem_memr; mem_rd = s.mem_rd; dmem_busy = s.busy;
      dbg_halt = s.halt; dbg_step = s.step;
   endtask

   // Called at posedge+1; returns at the next posedge+1.
   task automatic cycle(input stim_t s);
      exp_t e;
      apply(s);
      e = predict(s);
      sb.push_back(e);
      @(posedge clk);
      if (reset) model_reset();
      else advance(s, e);
      #1;
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("enables", {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we}, e.en);
            check("if_id_flush", if_id_flush, e.flush);
            check("id_ex_bubble", id_ex_bubble, e.bubble);
            check("stall_cause", stall_cause, e.cause);
            check("halted", halted, e.halted);
            check("stall_cnt", stall_cnt, e.scnt);
            check("flush_cnt", flush_cnt, e.fcnt);
            if (pc_we) n_pcwe++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      stim_t z, s;
      int    k, p0;
      bit    halt_lvl;
      z = '{default: '0};
      model_reset();
      reset = 1'b1;
      apply(z);
      @(posedge clk); #1;
      cycle(z);                       // reset state via scoreboard
      check("reset_halted", halted, 0);
      reset = 1'b0;
      cycle(z);

      // Load-use: one stall, then normal.
      s = z; s.ex_memr = 1; s.ex_regw = 1; s.ex_rd = 5; s.rs1 = 5; s.use1 = 1;
      cycle(s); cycle(z);
      // Branch with ALU producer in EX: one stall.
      s = z; s.br = 1; s.rs2 = 7; s.use2 = 1; s.ex_regw = 1; s.ex_rd = 7;
      cycle(s);
      s = z; s.br = 1; s.rs2 = 7; s.use2 = 1; s.mem_rd = 7;
      cycle(s); cycle(z);
      // Branch with load producer: EX then MEM.
      s = z; s.br = 1; s.rs2 = 7; s.use2 = 1; s.ex_regw = 1; s.ex_memr = 1; s.ex_rd = 7;
      cycle(s);
      s = z; s.br = 1; s.rs2 = 7; s.use2 = 1; s.mem_memr = 1; s.mem_rd = 7;
      cycle(s);
      s = z; s.br = 1; s.rs2 = 7; s.use2 = 1;
      cycle(s); cycle(z);
      // Taken branch flush; x0 never a hazard.
      s = z; s.br = 1; s.tk = 1; cycle(s); cycle(z);
      s = z; s.ex_memr = 1; s.ex_regw = 1; s.ex_rd = 0; s.rs1 = 0; s.use1 = 1; cycle(s);
      // Freeze over load-use for 3 cycles, then the stall.
      s = z; s.ex_memr = 1; s.ex_regw = 1; s.ex_rd = 5; s.rs1 = 5; s.use1 = 1; s.busy = 1;
      cycle(s); cycle(s); cycle(s);
      s.busy = 0; cycle(s); cycle(z);

      // Halt latency.
      s = z; s.halt = 1; k = 0;
      for (int i = 1; i <= 10; i++) begin
         cycle(s);
         if (halted === 1'b1) begin k = i; break; end
      end
      check("halt_latency", k, DRAIN + 1);
      // Single step: exactly one advancing cycle, then halted again.
      p0 = n_pcwe;
      s.step = 1; cycle(s); s.step = 0;
      for (int i = 0; i < 8; i++) cycle(s);
      check("step_pc_we_cycles", n_pcwe - p0, 1);
      check("step_rehalt", halted, 1);
      s.halt = 0; cycle(s);
      check("resume_run", halted, 0);
      cycle(z);

      // Random traffic.
      halt_lvl = 0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 19) == 0) halt_lvl = !halt_lvl;
         s.rs1 = 5'($urandom_range(0, 3)); s.rs2 = 5'($urandom_range(0, 3));
         s.use1 = 1'($urandom_range(0, 1)); s.use2 = 1'($urandom_range(0, 1));
         s.br = ($urandom_range(0, 2) == 0);
         s.tk = s.br && ($urandom_range(0, 1) == 1);
         s.ex_regw = 1'($urandom_range(0, 1));
         s.ex_memr = s.ex_regw && ($urandom_range(0, 1) == 1);
         s.ex_rd = 5'($urandom_range(0, 3));
         s.mem_memr = 1'($urandom_range(0, 1)); s.mem_rd = 5'($urandom_range(0, 3));
         s.busy = ($urandom_range(0, 4) == 0);
         s.halt = halt_lvl; s.step = ($urandom_range(0, 3) == 0);
         cycle(s);
      end
      for (int i = 0; i < 8; i++) cycle(z);

      // Reset in the middle of a drain.
      s = z; s.halt = 1; cycle(s); cycle(s);
      apply(z); reset = 1'b1; #1;
      check("mid_drain_rst_halted", halted, 0);
      check("mid_drain_rst_pc_we", pc_we, 1);
      check("mid_drain_rst_stall_cnt", stall_cnt, 0);
      check("mid_drain_rst_flush_cnt", flush_cnt, 0);
      model_reset();
      cycle(z);
      reset = 1'b0;
      cycle(z); cycle(z);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush/freeze sequencer for the 5-stage RV32 pipeline. It detects load-use and branch-operand hazards that the forwarding unit cannot resolve, squashes the wrong-path fetch after a taken branch resolved in ID, and freezes every stage while data memory is busy. It also provides a debug halt/single-step FSM. It drives the write enables of the PC and all four pipeline registers, plus the IF/ID flush and ID/EX bubble controls.

## Interface
Parameters:
- DRAIN_CYCLES, 3, cycles needed to empty ID/EX, EX/MEM and MEM/WB after issue stops.
- CNT_W, 32, perf-counter width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in IF/ID.
- id_use_rs1, id_use_rs2  in  1 each  the instruction really reads that source.
- id_branch  in  1  IF/ID holds a branch.
- id_branch_taken  in  1  branch compare in ID is true (PCSrc).
- ex_regw, ex_memr  in  1 each  RegWrite / MemRead of ID/EX.
- ex_rd  in  5  destination register of ID/EX.
- mem_memr  in  1  MemRead of EX/MEM.
- mem_rd  in  5  destination register of EX/MEM.
- dmem_busy  in  1  data memory cannot complete this cycle.
- dbg_halt  in  1  level; request halt.
- dbg_step  in  1  pulse; issue one instruction while halted.
- pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we  out  1 each  stage register enables.
- if_id_flush  out  1  load NOP into IF/ID.
- id_ex_bubble  out  1  load zero control into ID/EX.
- halted  out  1  FSM in HALTED.
- stall_cause  out  3  0 none, 1 load-use, 2 branch-operand, 3 dmem freeze, 4 debug.
- stall_cnt, flush_cnt  out  CNT_W each  perf counters.

## Operation
- Registers x0 never create a hazard (rd==0 is ignored).
- load_use = ex_memr & ex_rd matches a used source.
- br_hazard = id_branch & ((ex_regw & ex_rd matches a used source) | (mem_memr & mem_rd matches a used source)).
- Priority, highest first:
  1. dmem_busy: all five enables are 0, flush=0, bubble=0.
  2. load_use or br_hazard: pc_we=0, if_id_we=0, id_ex_bubble=1, and the later stages are enabled.
  3. id_branch_taken: all stages are enabled and if_id_flush=1.
  4. Otherwise all enables are 1.
- FSM states: RUN, DRAIN, HALTED, STEP.
  - RUN goes to DRAIN when dbg_halt=1.
  - DRAIN: pc_we=0, if_id_we=0, id_ex_bubble=1. A down-counter is loaded with DRAIN_CYCLES and decrements only on non-frozen cycles. At 0 the FSM goes to HALTED, even if dbg_halt has dropped.
  - HALTED: all enables are 0. If dbg_halt=0 the FSM goes to RUN. Otherwise dbg_step moves it to STEP.
  - STEP behaves like RUN until one advancing cycle occurs (pc_we=1), then goes to DRAIN.
  - dbg_step outside HALTED is ignored.
- In DRAIN and STEP, the hazard and flush rules still apply. A taken branch in STEP flushes IF/ID.
- Arithmetic: the drain counter is 2 bits. The perf counters wrap modulo 2^CNT_W.

## Timing
- All control outputs are combinational from the inputs and the current state. State, drain counter and perf counters update on the rising edge of clk.
- Reset values: state RUN, counter 0, stall_cnt=0, flush_cnt=0, halted=0. With all inputs at 0 during reset: all enables=1, flush=0, bubble=0, stall_cause=0.
- A load-use stall lasts exactly 1 cycle.
- A branch hazard with an ALU producer in EX lasts 1 cycle. With a load producer it lasts 2 cycles (EX, then MEM).
- A flush lasts 1 cycle per taken branch.
- Halt latency: halted rises DRAIN_CYCLES+1 edges after dbg_halt is sampled, if there is no freeze.
- If reset asserts mid-DRAIN or mid-STEP, the FSM returns to RUN immediately.
- If dmem_busy and a hazard occur in the same cycle, freeze wins. The hazard is re-evaluated once freeze drops.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt increments on each cycle with pc_we=0 in RUN or STEP.
  - flush_cnt increments on each cycle with if_id_flush=1.
- Undefined: both counter ports are tied to 0 and no counter flops are built.

## Structure
- Shared package holds:
  - the FSM state enum (RUN, DRAIN, HALTED, STEP),
  - the stall_cause encodings,
  - the DRAIN_CYCLES default.
- Sub-module hazard_detect (purely combinational) computes load_use and br_hazard. The top-level block holds the priority logic, the FSM and the counters.

## Test plan
- Set ex_memr=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> for 1 cycle pc_we=0, if_id_we=0, id_ex_bubble=1, stall_cause=1. Then normal operation.
- Branch in ID with id_rs2=7, ex_regw=1, ex_rd=7 -> 1 stall cycle with cause 2. Repeat with a load producer -> 2 stall cycles.
- id_branch_taken=1 with no hazard -> if_id_flush=1 for 1 cycle with all enables=1. Also set ex_rd=0 with a match on x0 -> no stall.
- Hold dmem_busy for 3 cycles during a load-use condition -> all enables=0 and cause=3 for 3 cycles, then one load-use stall.
- Raise dbg_halt -> halted=1 after 4 edges. Pulse dbg_step -> exactly one pc_we=1 cycle, then halted again after the drain. Drop dbg_halt -> RUN.
- With HAZARD_PERF_CNT_EN, run the sequence above -> stall_cnt and flush_cnt equal the counted events. Assert reset mid-DRAIN -> counters=0, halted=0.
